// File: rtl/mips_pkg.sv
// Shared command opcodes and controller state encodings for the pipeline step controller.
package mips_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StStep   = 3'd2,
        StHalted = 3'd3,
        StPreset = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CmdNop    = 3'd0,
        CmdRun    = 3'd1,
        CmdStep   = 3'd2,
        CmdHalt   = 3'd3,
        CmdPreset = 3'd4
    } cmd_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_step_controller.sv
// Run/step/halt/program-reset controller that gates a pipeline's enable and counts its cycles.
module pipeline_step_controller
    import mips_pkg::*;
#(
    parameter int unsigned CYCLE_W       = 32,
    parameter int unsigned STEP_W        = 8,
    parameter int unsigned PRESET_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    input  logic [2:0]         i_cmd,
    input  logic [STEP_W-1:0]  i_cmd_arg,
    output logic               o_cmd_ready,
    input  logic               i_halt_instr,
    input  logic               i_hold,
    output logic               o_pipe_en,
    output logic               o_prog_reset,
    output logic               o_done,
    output logic               o_cmd_err,
    output logic [2:0]         o_state,
    output logic [CYCLE_W-1:0] o_cycle_count
);

    localparam int unsigned PresetW = (PRESET_CYCLES > 1) ? $clog2(PRESET_CYCLES) : 1;
    localparam logic [PresetW-1:0] PresetLoad = PresetW'(PRESET_CYCLES - 1);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [PresetW-1:0]  preset_cnt_q, preset_cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cmd_acc;
    logic                pipe_en;
    logic                halt_hit;

    assign o_cmd_ready = (state_q == StIdle) || (state_q == StRun) || (state_q == StHalted);
    assign cmd_acc     = i_cmd_valid && o_cmd_ready;
    assign pipe_en     = !i_hold && ((state_q == StRun) ||
                                     ((state_q == StStep) && (step_cnt_q != '0)));
    // A halt instruction only counts when it actually retires.
    assign halt_hit    = pipe_en && i_halt_instr;

    always_comb begin
        state_d      = state_q;
        step_cnt_d   = step_cnt_q;
        preset_cnt_d = preset_cnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_acc) begin
                    case (i_cmd)
                        CmdRun:  state_d = StRun;
                        CmdStep: begin
                            state_d    = StStep;
                            step_cnt_d = (i_cmd_arg == '0) ? STEP_W'(1) : i_cmd_arg;
                        end
                        CmdPreset: begin
                            state_d      = StPreset;
                            preset_cnt_d = PresetLoad;
                        end
                        CmdNop, CmdHalt: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StRun: begin
                // Retiring halt wins over any command offered the same cycle.
                if (halt_hit) begin
                    state_d = StHalted;
                    done_d  = 1'b1;
                end else if (cmd_acc) begin
                    case (i_cmd)
                        CmdHalt: begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                        CmdPreset: begin
                            state_d      = StPreset;
                            preset_cnt_d = PresetLoad;
                        end
                        CmdNop:  ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StStep: begin
                if (pipe_en) begin
                    step_cnt_d = step_cnt_q - STEP_W'(1);
                    if (i_halt_instr) begin
                        state_d = StHalted;
                        done_d  = 1'b1;
                    end else if (step_cnt_q == STEP_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StHalted: begin
                if (cmd_acc) begin
                    if (i_cmd == CmdPreset) begin
                        state_d      = StPreset;
                        preset_cnt_d = PresetLoad;
                    end else if (i_cmd != CmdNop) begin
                        err_d = 1'b1;
                    end
                end
            end
            StPreset: begin
                if (preset_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    preset_cnt_d = preset_cnt_q - PresetW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            step_cnt_q   <= '0;
            preset_cnt_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_cnt_q   <= step_cnt_d;
            preset_cnt_q <= preset_cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    sat_counter #(
        .WIDTH (CYCLE_W)
    ) u_cycle_counter (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .inc   (pipe_en),
        .clr   (state_q == StPreset),
        .count (o_cycle_count)
    );

    assign o_pipe_en    = pipe_en;
    assign o_prog_reset = (state_q == StPreset);
    assign o_done       = done_q;
    assign o_cmd_err    = err_q;
    assign o_state      = state_q;

endmodule

// File: doc/pipeline_step_controller.md
PIPELINE_STEP_CONTROLLER -- requirements
Module: pipeline_step_controller

Interface
REQ-001 SHALL have parameter CYCLE_W, default 32: cycle-counter width.
REQ-002 SHALL have parameter STEP_W, default 8: step-count argument width.
REQ-003 SHALL have parameter PRESET_CYCLES, default 2: program-reset pulse length in cycles, minimum 1.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_cmd_valid, input, 1: the command on i_cmd/i_cmd_arg is offered this cycle.
REQ-007 SHALL have port i_cmd, input, 3: command opcode, one of NOP=0, RUN=1, STEP=2, HALT=3, PRESET=4; codes 5-7 are illegal.
REQ-008 SHALL have port i_cmd_arg, input, STEP_W: step count for STEP; 0 is treated as 1.
REQ-009 SHALL have port o_cmd_ready, output, 1: the controller accepts a command this cycle.
REQ-010 SHALL have port i_halt_instr, input, 1: a halt instruction is in write-back.
REQ-011 SHALL have port i_hold, input, 1: instruction memory is being written; freezes the pipeline.
REQ-012 SHALL have port o_pipe_en, output, 1: the pipeline advances this cycle.
REQ-013 SHALL have port o_prog_reset, output, 1: program reset to PC, pipeline latches and register file.
REQ-014 SHALL have port o_done, output, 1: one-cycle pulse when a run or step completes.
REQ-015 SHALL have port o_cmd_err, output, 1: one-cycle pulse when an accepted command is ignored or illegal.
REQ-016 SHALL have port o_state, output, 3: current state encoding.
REQ-017 SHALL have port o_cycle_count, output, CYCLE_W: number of enabled pipeline cycles.

Function
REQ-018 SHALL use states IDLE=0, RUN=1, STEP=2, HALTED=3, PRESET=4.
REQ-019 A command SHALL be accepted on a cycle with i_cmd_valid && o_cmd_ready; o_cmd_ready SHALL be 1 in IDLE, RUN and HALTED, and 0 in STEP and PRESET.
REQ-020 In IDLE: RUN -> RUN; STEP -> STEP, with step counter = max(i_cmd_arg, 1); PRESET -> PRESET; HALT, NOP -> stay, no error; illegal code -> stay, o_cmd_err.
REQ-021 o_pipe_en SHALL be combinational: 1 in RUN, and in STEP while the step counter is nonzero, each gated by ~i_hold; 0 in every other state.
REQ-022 In RUN: i_halt_instr && o_pipe_en -> HALTED with o_done; accepted HALT -> IDLE with o_done; accepted PRESET -> PRESET; accepted RUN, STEP or illegal -> o_cmd_err, stay in RUN.
REQ-023 In RUN, if i_halt_instr and an accepted HALT occur in the same cycle, the block SHALL go to HALTED with a single o_done pulse.
REQ-024 In STEP: the counter SHALL decrement on each o_pipe_en cycle; an enabled cycle with counter==1 -> IDLE with o_done; i_halt_instr && o_pipe_en -> HALTED with o_done, taking priority over counter expiry.
REQ-025 With i_hold=1 in STEP, the counter SHALL hold and the state SHALL not change.
REQ-026 In HALTED: only PRESET is honoured (-> PRESET); every other accepted non-NOP code SHALL pulse o_cmd_err.
REQ-027 In PRESET: o_prog_reset SHALL be 1 for exactly PRESET_CYCLES cycles, o_cycle_count SHALL clear, then -> IDLE with no o_done.
REQ-028 o_cycle_count SHALL increment by 1 on each o_pipe_en cycle and saturate at all-ones.
REQ-029 o_done and o_cmd_err SHALL be registered, asserting in the cycle after the triggering edge, and SHALL never assert together.
REQ-030 i_halt_instr SHALL be ignored while o_pipe_en=0.

Reset
REQ-031 With i_rst=1 at a clock edge, the block SHALL go to IDLE, set the step counter, the PRESET counter and o_cycle_count to 0, and set o_done=0, o_cmd_err=0 and o_prog_reset=0, at any point in operation.
REQ-032 After reset, o_pipe_en SHALL be 0, o_cmd_ready SHALL be 1 and o_state SHALL be 0 until a command is accepted.

Structure
REQ-033 Command codes and state encodings SHALL live in the shared package mips_pkg.
REQ-034 A single sub-module, sat_counter (parameter width; inputs inc, clr; output saturating count), SHALL implement o_cycle_count.
REQ-035 The next-state logic SHALL be one combinational block, with one registered state and counter block.

Verification
REQ-036 Reset; STEP with arg=3 -> o_pipe_en high for 3 cycles, o_done pulse, state IDLE, o_cycle_count=3.
REQ-037 STEP with arg=0 -> exactly 1 enabled cycle; STEP with arg=4 and i_hold=1 on cycle 2 -> 4 enabled cycles over 5 clocks.
REQ-038 RUN, then i_halt_instr after 10 enabled cycles -> HALTED, one o_done, count=10; a RUN then -> o_cmd_err, and a PRESET then -> o_prog_reset for 2 cycles, count=0, IDLE.
REQ-039 In RUN, i_halt_instr and HALT in the same cycle -> HALTED, single o_done; illegal code 6 in IDLE -> o_cmd_err, state unchanged.
REQ-040 i_rst asserted mid-STEP (counter=5) -> IDLE next cycle, o_pipe_en=0, count=0; with CYCLE_W=4, 20 enabled cycles -> o_cycle_count=15.
